ddc_avg: RTL and testbench
==========================

DDC_AVG -- requirements
Module: ddc_avg

Interface
REQ-001 Parameter NAVG_MAX_LOG2, default 8; largest allowed log2 of the block length.
REQ-002 Parameter SEQ_W, default 24; width of the frame sequence counter.
REQ-003 SYS_CLK  in  1  the one clock (10 MHz DDC112 system clock); all logic on its rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  1-cycle strobe from the readout stage marking in_data valid.
REQ-006 in_data  in  64  readout word: [19:0] channel-1 code, [39:20] channel-2 code, [63:40] ignored.
REQ-007 log2_navg  in  4  block length = 2^log2_navg conversions; values above NAVG_MAX_LOG2 clamp to NAVG_MAX_LOG2.
REQ-008 fifo_full  in  1  full flag of the downstream 64-in/32-out FIFO.
REQ-009 clr_ovf  in  1  1-cycle strobe that clears ovf.
REQ-010 out_data  out  64  [19:0] ch1 average, [39:20] ch2 average, [63:40] sequence number.
REQ-011 out_wr  out  1  1-cycle FIFO write strobe qualifying out_data.
REQ-012 ovf  out  1  sticky flag: a result was dropped because fifo_full was high.
REQ-013 busy  out  1  high while a block is partially accumulated.

Function
REQ-014 The FSM SHALL use the states IDLE, ACCUM, and EMIT.
REQ-015 IDLE + in_valid: latch the clamped log2_navg, load both sums with the sample, set count=1; go to EMIT if the length is 1, else ACCUM.
REQ-016 ACCUM + in_valid: add the sample to each 28-bit unsigned sum and increment count; go to EMIT when count reaches 2^latched value.
REQ-017 EMIT: the FSM SHALL stay one cycle, then return to IDLE.
REQ-018 out_wr SHALL assert in the EMIT cycle (exactly 1 cycle after the completing in_valid) unless fifo_full is high in that cycle.
REQ-019 out_data SHALL be valid with out_wr: each channel average = sum >> latched log2 (truncation), giving 20 bits.
REQ-020 The sequence counter SHALL increment on every EMIT, written or dropped, and SHALL wrap from 2^SEQ_W-1 to 0.
REQ-021 EMIT with fifo_full=1: out_wr stays low and ovf sets; ovf holds until clr_ovf or RST.
REQ-022 Simultaneous ovf set and clr_ovf: the set wins.
REQ-023 in_valid during EMIT: start a new block with that sample (IDLE+in_valid action); no sample is lost.
REQ-024 A change of log2_navg mid-block SHALL be ignored until the next block starts.
REQ-025 in_data[63:40] SHALL have no effect on any output.
REQ-026 busy SHALL be 1 in ACCUM and 0 in IDLE and EMIT.

Reset
REQ-027 RST SHALL asynchronously force IDLE and clear sums, count, sequence, latched length, out_data, out_wr, ovf, and busy.
REQ-028 RST mid-block SHALL discard the partial sums; the first in_valid after release starts a fresh block with sequence 0.

Structure
REQ-029 Shared package ddc_pkg SHALL hold the constants CODE_W=20, SUM_W=28, the channel field offsets, and the state enumeration.
REQ-030 One sub-module, ddc_chan_acc (load/add/shift for one channel), SHALL be instantiated twice; the FSM, counters, and flags stay in ddc_avg.

Verification
REQ-031 log2_navg=0, samples ch1=0x12345, ch2=0xFFFFF -> out_wr 1 cycle later, out_data = {seq 0, 0xFFFFF, 0x12345}.
REQ-032 log2_navg=2, ch1 samples 10, 11, 12, 14 -> one out_wr after the 4th; ch1 average = 11; busy high during samples 1-3.
REQ-033 log2_navg=8, 256 samples of 0xFFFFF on both channels -> average 0xFFFFF (no sum overflow); log2_navg=15 behaves identically.
REQ-034 fifo_full=1 during EMIT -> no out_wr, ovf=1, next result carries seq+2; clr_ovf in the same cycle as a new drop -> ovf stays 1.
REQ-035 Back-to-back in_valid with log2_navg=0 on consecutive cycles -> out_wr on consecutive cycles with sequences 0, 1, 2; seq wraps 0xFFFFFF -> 0.
REQ-036 RST asserted after 2 of 4 samples -> all outputs 0 immediately; 4 new samples -> a single result with seq 0 that uses only the post-reset data.

Source files
------------

// File: rtl/ddc_pkg.sv
// Shared constants and FSM encoding for the DDC112 block averager.
// Field offsets describe both the readout word and the result word.
package ddc_pkg;

  localparam int CODE_W  = 20;
  localparam int SUM_W   = 28;
  localparam int WORD_W  = 64;
  localparam int CH1_LSB = 0;
  localparam int CH2_LSB = 20;
  localparam int SEQ_LSB = 40;
  localparam int OSEQ_W  = WORD_W - SEQ_LSB;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

endpackage

// File: rtl/ddc_chan_acc.sv
// One channel of the averager: load/accumulate a 28-bit sum and
// present the truncated average for the latched block length.
import ddc_pkg::*;

module ddc_chan_acc (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_add,
  input  logic [CODE_W-1:0] i_code,
  input  logic [3:0]        i_shift,
  output logic [CODE_W-1:0] o_avg
);

  logic [SUM_W-1:0] r_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (i_load) begin
      r_sum <= SUM_W'(i_code);
    end else if (i_add) begin
      r_sum <= r_sum + SUM_W'(i_code);
    end
  end

  assign o_avg = CODE_W'(r_sum >> i_shift);

endmodule

// File: rtl/ddc_avg.sv
// Block averager for the two DDC112 channels with sequence tagging,
// FIFO-full drop detection and a sticky overflow flag.
import ddc_pkg::*;

module ddc_avg #(
  parameter int NAVG_MAX_LOG2 = 8,
  parameter int SEQ_W         = 24
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic [3:0]        log2_navg,
  input  logic              fifo_full,
  input  logic              clr_ovf,
  output logic [WORD_W-1:0] out_data,
  output logic              out_wr,
  output logic              ovf,
  output logic              busy
);

  localparam int         CNT_W   = NAVG_MAX_LOG2 + 1;
  localparam logic [3:0] LEN_MAX = 4'(NAVG_MAX_LOG2);

  state_t           r_state;
  state_t           w_nxt;
  logic [3:0]       r_len;
  logic [3:0]       w_len;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_target;
  logic [SEQ_W-1:0] r_seq;
  logic             r_ovf;
  logic             w_load;
  logic             w_add;
  logic             w_done;
  logic             w_emit;
  logic             w_unused;

  logic [CODE_W-1:0] w_avg1;
  logic [CODE_W-1:0] w_avg2;

  assign w_len     = (log2_navg > LEN_MAX) ? LEN_MAX : log2_navg;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_target  = CNT_W'(1) << r_len;
  assign w_done    = (w_cnt_inc == w_target);
  assign w_emit    = (r_state == EMIT);
  assign w_unused  = ^in_data[WORD_W-1:SEQ_LSB];

  // EMIT behaves like IDLE for a new sample so back-to-back blocks lose nothing
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_add  = 1'b0;
    unique case (r_state)
      ACCUM: begin
        if (in_valid) begin
          w_add = 1'b1;
          if (w_done) w_nxt = EMIT;
        end
      end
      default: begin
        if (in_valid) begin
          w_load = 1'b1;
          w_nxt  = (w_len == 4'd0) ? EMIT : ACCUM;
        end else begin
          w_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_seq   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_load) begin
        r_len <= w_len;
        r_cnt <= CNT_W'(1);
      end else if (w_add) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_emit) r_seq <= r_seq + 1'b1;
      if (w_emit && fifo_full) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  ddc_chan_acc u_ch1 (
    .clk     (SYS_CLK),
    .rst     (RST),
    .i_load  (w_load),
    .i_add   (w_add),
    .i_code  (in_data[CH1_LSB +: CODE_W]),
    .i_shift (r_len),
    .o_avg   (w_avg1)
  );

  ddc_chan_acc u_ch2 (
    .clk     (SYS_CLK),
    .rst     (RST),
    .i_load  (w_load),
    .i_add   (w_add),
    .i_code  (in_data[CH2_LSB +: CODE_W]),
    .i_shift (r_len),
    .o_avg   (w_avg2)
  );

  assign out_data = {OSEQ_W'(r_seq), w_avg2, w_avg1};
  assign out_wr   = w_emit & ~fifo_full;
  assign ovf      = r_ovf;
  assign busy     = (r_state == ACCUM);

endmodule

// File: tb/tb_ddc_avg.sv
// Scoreboard bench for ddc_avg: expected result words are queued as
// samples are driven and popped when the FIFO write strobe fires.
`timescale 1ns/1ps

module tb_ddc_avg;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [3:0]  log2_navg = '0;
  logic        fifo_full = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [63:0] out_data;
  logic        out_wr;
  logic        ovf;
  logic        busy;

  logic        w_valid = 1'b0;
  logic [63:0] w_data = '0;
  logic [3:0]  w_log2 = '0;
  logic        w_full = 1'b0;
  logic        w_clr = 1'b0;
  logic [63:0] w_out;
  logic        w_wr;
  logic        w_ovf;
  logic        w_busy;

  int checks = 0;
  int errors = 0;
  int m_seq = 0;
  logic [63:0] sb[$];
  logic [63:0] sbw[$];
  logic [63:0] mon_exp;
  logic [63:0] monw_exp;

  always #50 SYS_CLK = ~SYS_CLK;

  ddc_avg u_dut (
    .SYS_CLK   (SYS_CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .log2_navg (log2_navg),
    .fifo_full (fifo_full),
    .clr_ovf   (clr_ovf),
    .out_data  (out_data),
    .out_wr    (out_wr),
    .ovf       (ovf),
    .busy      (busy)
  );

  ddc_avg #(.NAVG_MAX_LOG2(8), .SEQ_W(3)) u_wrap (
    .SYS_CLK   (SYS_CLK),
    .RST       (RST),
    .in_valid  (w_valid),
    .in_data   (w_data),
    .log2_navg (w_log2),
    .fifo_full (w_full),
    .clr_ovf   (w_clr),
    .out_data  (w_out),
    .out_wr    (w_wr),
    .ovf       (w_ovf),
    .busy      (w_busy)
  );

  function automatic logic [63:0] exp_word(input int seq,
                                           input logic [27:0] s1,
                                           input logic [27:0] s2,
                                           input int l);
    logic [27:0] a1;
    logic [27:0] a2;
    a1 = s1 >> l;
    a2 = s2 >> l;
    return {24'(seq), a2[19:0], a1[19:0]};
  endfunction

  always @(negedge SYS_CLK) begin
    if (!RST && out_wr) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wr: out_data=%h, no result expected",
                 out_data);
      end else begin
        mon_exp = sb.pop_front();
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL out_data: got %h expected %h",
                   out_data, mon_exp);
        end
      end
    end
  end

  always @(negedge SYS_CLK) begin
    if (!RST && w_wr) begin
      checks++;
      if (sbw.size() == 0) begin
        errors++;
        $display("FAIL wrap_unexpected_wr: out_data=%h", w_out);
      end else begin
        monw_exp = sbw.pop_front();
        if (w_out !== monw_exp) begin
          errors++;
          $display("FAIL wrap_out_data: got %h expected %h",
                   w_out, monw_exp);
        end
      end
    end
  end

  task automatic send(input logic [19:0] c1, input logic [19:0] c2);
    in_valid = 1'b1;
    in_data  = {24'($urandom), c2, c1};
    @(posedge SYS_CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    @(posedge SYS_CLK);
    #1;
    checks++;
    if (out_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_out_data: got %h expected 0", out_data);
    end
    checks++;
    if (out_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_wr: got %b expected 0", out_wr);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b expected 0", ovf);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    RST = 1'b0;
    m_seq = 0;
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic test_single();
    log2_navg = 4'd0;
    sb.push_back(exp_word(m_seq, 28'h12345, 28'hFFFFF, 0));
    m_seq++;
    send(20'h12345, 20'hFFFFF);
    checks++;
    if (out_wr !== 1'b1) begin
      errors++;
      $display("FAIL single_wr_latency: got %b expected 1", out_wr);
    end
    @(posedge SYS_CLK);
    #1;
    checks++;
    if (out_wr !== 1'b0) begin
      errors++;
      $display("FAIL single_wr_width: got %b expected 0", out_wr);
    end
  endtask

  task automatic test_avg4();
    logic [19:0] c1[4];
    logic [19:0] c2[4];
    logic [27:0] s1;
    logic [27:0] s2;
    c1 = '{20'd10, 20'd11, 20'd12, 20'd14};
    c2 = '{20'd100, 20'd200, 20'd300, 20'd401};
    s1 = '0;
    s2 = '0;
    for (int i = 0; i < 4; i++) begin
      s1 += 28'(c1[i]);
      s2 += 28'(c2[i]);
    end
    log2_navg = 4'd2;
    sb.push_back(exp_word(m_seq, s1, s2, 2));
    m_seq++;
    for (int i = 0; i < 4; i++) begin
      send(c1[i], c2[i]);
      log2_navg = 4'd0;
      if (i < 3) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL avg4_busy_s%0d: got %b expected 1", i + 1, busy);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL avg4_busy_emit: got %b expected 0", busy);
    end
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic test_full_scale();
    int lens[2];
    logic [27:0] s;
    int nl;
    lens = '{8, 15};
    for (int k = 0; k < 2; k++) begin
      log2_navg = 4'(lens[k]);
      nl = (lens[k] > 8) ? 8 : lens[k];
      s = '0;
      for (int i = 0; i < (1 << nl); i++) begin
        s += 28'hFFFFF;
        if (i == (1 << nl) - 1) begin
          sb.push_back(exp_word(m_seq, s, s, nl));
          m_seq++;
        end
        send(20'hFFFFF, 20'hFFFFF);
      end
      @(posedge SYS_CLK);
      #1;
    end
  endtask

  task automatic test_overflow();
    log2_navg = 4'd0;
    send(20'd1, 20'd2);
    m_seq++;
    fifo_full = 1'b1;
    @(posedge SYS_CLK);
    #1;
    fifo_full = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 1", ovf);
    end
    sb.push_back(exp_word(m_seq, 28'd3, 28'd4, 0));
    m_seq++;
    send(20'd3, 20'd4);
    @(posedge SYS_CLK);
    #1;
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b expected 1", ovf);
    end
    send(20'd5, 20'd6);
    m_seq++;
    fifo_full = 1'b1;
    clr_ovf = 1'b1;
    @(posedge SYS_CLK);
    #1;
    fifo_full = 1'b0;
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: got %b expected 1", ovf);
    end
    clr_ovf = 1'b1;
    @(posedge SYS_CLK);
    #1;
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] v;
    RST = 1'b1;
    #5;
    RST = 1'b0;
    m_seq = 0;
    log2_navg = 4'd0;
    for (int i = 0; i < 3; i++) begin
      v = 20'(32'h1000 + i * 32'h111);
      sb.push_back(exp_word(m_seq, 28'(v), 28'(~v), 0));
      m_seq++;
      send(v, ~v);
      checks++;
      if (out_wr !== 1'b1) begin
        errors++;
        $display("FAIL b2b_wr_%0d: got %b expected 1", i, out_wr);
      end
    end
    @(posedge SYS_CLK);
    #1;
    checks++;
    if (out_wr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wr_end: got %b expected 0", out_wr);
    end
  endtask

  task automatic test_wrap();
    int wseq;
    logic [19:0] a;
    logic [19:0] b;
    wseq = 0;
    for (int i = 0; i < 10; i++) begin
      a = 20'(i + 1);
      b = 20'(i * 3 + 7);
      sbw.push_back({24'(wseq), b, a});
      wseq = (wseq + 1) % 8;
      w_valid = 1'b1;
      w_data = {24'hABCDEF, b, a};
      @(posedge SYS_CLK);
      #1;
    end
    w_valid = 1'b0;
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic test_rst_mid();
    logic [27:0] s1;
    logic [27:0] s2;
    log2_navg = 4'd2;
    send(20'd900, 20'd900);
    send(20'd800, 20'd800);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy_pre: got %b expected 1", busy);
    end
    #10 RST = 1'b1;
    #1;
    checks++;
    if (out_data !== 64'd0 || out_wr !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outs: got data=%h wr=%b expected 0/0",
               out_data, out_wr);
    end
    checks++;
    if (busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_flags: got busy=%b ovf=%b expected 0/0",
               busy, ovf);
    end
    @(posedge SYS_CLK);
    #1;
    RST = 1'b0;
    m_seq = 0;
    s1 = '0;
    s2 = '0;
    for (int i = 0; i < 4; i++) begin
      s1 += 28'(20 + i);
      s2 += 28'(400 + 4 * i);
    end
    sb.push_back(exp_word(m_seq, s1, s2, 2));
    m_seq++;
    for (int i = 0; i < 4; i++) begin
      send(20'(20 + i), 20'(400 + 4 * i));
    end
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic test_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || sbw.size() != 0) && n < 20) begin
      @(posedge SYS_CLK);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || sbw.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d results pending expected 0/0",
               sb.size(), sbw.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_avg4();
    test_full_scale();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_rst_mid();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
